// File: rtl/mem_pkg.sv
// Shared definitions for the MainMemory port arbiter.
//   arb_state_t : arbiter FSM states
//   SIZE_*      : access-size encodings seen on d_size / mm_size
//   DEAD_BEEF   : load data returned on an aborted data access
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_ACC   = 2'd1,
        D_ACC   = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    localparam logic [1:0]  SIZE_BYTE = 2'd0;
    localparam logic [1:0]  SIZE_HALF = 2'd1;
    localparam logic [1:0]  SIZE_WORD = 2'd2;

    localparam logic [31:0] DEAD_BEEF = 32'hdead_beef;

endpackage

// File: rtl/line_addr_gen.sv
// Instruction line-fill address generator.
// Holds the line base (offset bits cleared) and the word counter, and forms
// the MainMemory port-1 word address from them.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture line_addr base and clear the word counter
//   inc        : advance the word counter (wraps to 0 after the last word)
//   line_addr  : requested line word address (offset bits ignored)
//   addr       : {base, counter} word address for MainMemory port 1
//   last       : counter points at the last word of the line
module line_addr_gen
    import mem_pkg::*;
#(
    parameter int WORDS_PER_LINE = 8,
    parameter int IADDR_W        = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               inc,
    input  logic [IADDR_W-1:0] line_addr,
    output logic [IADDR_W-1:0] addr,
    output logic               last
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int BASE_W = IADDR_W - OFF_W;

    logic [BASE_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  cnt_q,  cnt_d;
    logic              unused_off_s;

    // The offset bits of the request are deliberately discarded.
    assign unused_off_s = ^line_addr[OFF_W-1:0];

    // Next base/counter: load wins over increment.
    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        if (load) begin
            base_d = line_addr[IADDR_W-1:OFF_W];
            cnt_d  = '0;
        end else if (inc) begin
            cnt_d = cnt_q + OFF_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Base and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr = {base_q, cnt_q};
    assign last = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one MainMemory between the instruction line-fill path and
// the data load/store port. Each word access holds its enable until the
// memory's valid, hands the data back, then spends one RECOVER cycle pulsing
// mm_rst so MainMemory's delay counter re-arms.
//   MEM_CLK, RST_N      : clock, asynchronous active-low reset
//   i_req/i_line_addr   : line-fill request; i_word_valid/i_word_data/i_done back
//   d_req/d_we/d_addr/d_wdata/d_size/d_sign : data request; d_valid/d_rdata back
//   mm_*1               : MainMemory port 1 (instruction, read only)
//   mm_*2, mm_size/sign : MainMemory port 2 (data)
//   mm_rst              : restart pulse (also high while RST_N is low)
//   busy                : FSM not in IDLE
// Optional build macro MEM_ARB_TIMEOUT_EN adds the TIMEOUT_CYC parameter and
// the sticky err_timeout output; stalled accesses then abort.
// A line burst is never preempted; data wins only when both request in IDLE.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int WORDS_PER_LINE = 8,
    parameter int IADDR_W        = 14
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC    = 64
`endif
) (
    input  logic               MEM_CLK,
    input  logic               RST_N,
    input  logic               i_req,
    input  logic [IADDR_W-1:0] i_line_addr,
    output logic               i_word_valid,
    output logic [31:0]        i_word_data,
    output logic               i_done,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    input  logic [1:0]         d_size,
    input  logic               d_sign,
    output logic               d_valid,
    output logic [31:0]        d_rdata,
    output logic               mm_rden1,
    output logic [IADDR_W-1:0] mm_addr1,
    input  logic [31:0]        mm_dout1,
    input  logic               mm_valid1,
    output logic               mm_rden2,
    output logic               mm_we2,
    output logic [31:0]        mm_addr2,
    output logic [31:0]        mm_din2,
    output logic [1:0]         mm_size,
    output logic               mm_sign,
    input  logic [31:0]        mm_dout2,
    input  logic               mm_valid2,
    output logic               mm_rst,
    output logic               busy
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic               err_timeout
`endif
);

    arb_state_t   state_q, state_d;
    logic         d_we_q,    d_we_d;
    logic [31:0]  d_addr_q,  d_addr_d;
    logic [31:0]  d_wdata_q, d_wdata_d;
    logic [1:0]   d_size_q,  d_size_d;
    logic         d_sign_q,  d_sign_d;
    logic         more_q,    more_d;    // burst still has words to fetch

    logic               lag_load_s;
    logic               lag_inc_s;
    logic [IADDR_W-1:0] lag_addr_s;
    logic               lag_last_s;
    logic               mm_rst_s;
    logic               timeout_s;

    line_addr_gen #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IADDR_W        (IADDR_W)
    ) u_line_addr_gen (
        .clk       (MEM_CLK),
        .rst_n     (RST_N),
        .load      (lag_load_s),
        .inc       (lag_inc_s),
        .line_addr (i_line_addr),
        .addr      (lag_addr_s),
        .last      (lag_last_s)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               err_q,   err_d;

    // Abort fires in the TIMEOUT_CYC-th access cycle that sees no valid.
    assign timeout_s = ((state_q == I_ACC) || (state_q == D_ACC)) &&
                       (timer_q == TIMER_W'(TIMEOUT_CYC - 1));

    // Access-cycle timer (zero outside accesses, so it clears on entry) and sticky error.
    always_comb begin
        if (((state_q == I_ACC) && !mm_valid1) || ((state_q == D_ACC) && !mm_valid2)) begin
            timer_d = timer_q + TIMER_W'(1);
        end else begin
            timer_d = '0;
        end
        if ((state_q == IDLE) && (d_req || i_req)) begin
            err_d = 1'b0;
        end else if (timeout_s && !((state_q == I_ACC) ? mm_valid1 : mm_valid2)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Timer and error registers.
    always_ff @(posedge MEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, request latching and per-state memory-port outputs.
    always_comb begin
        state_d      = state_q;
        d_we_d       = d_we_q;
        d_addr_d     = d_addr_q;
        d_wdata_d    = d_wdata_q;
        d_size_d     = d_size_q;
        d_sign_d     = d_sign_q;
        more_d       = more_q;
        lag_load_s   = 1'b0;
        lag_inc_s    = 1'b0;
        i_word_valid = 1'b0;
        i_word_data  = 32'h0000_0000;
        i_done       = 1'b0;
        d_valid      = 1'b0;
        d_rdata      = 32'h0000_0000;
        mm_rden1     = 1'b0;
        mm_addr1     = '0;
        mm_rden2     = 1'b0;
        mm_we2       = 1'b0;
        mm_addr2     = 32'h0000_0000;
        mm_din2      = 32'h0000_0000;
        mm_size      = 2'd0;
        mm_sign      = 1'b0;
        mm_rst_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d   = D_ACC;
                    d_we_d    = d_we;
                    d_addr_d  = d_addr;
                    d_wdata_d = d_wdata;
                    d_size_d  = d_size;
                    d_sign_d  = d_sign;
                end else if (i_req) begin
                    state_d    = I_ACC;
                    lag_load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            I_ACC: begin
                mm_rden1 = 1'b1;
                mm_addr1 = lag_addr_s;
                if (mm_valid1) begin
                    i_word_valid = 1'b1;
                    i_word_data  = mm_dout1;
                    i_done       = lag_last_s;
                    lag_inc_s    = 1'b1;
                    more_d       = !lag_last_s;
                    state_d      = RECOVER;
                end else if (timeout_s) begin
                    // Abandon the rest of the line; done without a word.
                    i_done  = 1'b1;
                    more_d  = 1'b0;
                    state_d = RECOVER;
                end else begin
                    state_d = I_ACC;
                end
            end
            D_ACC: begin
                mm_rden2 = !d_we_q;
                mm_we2   = d_we_q;
                mm_addr2 = d_addr_q;
                mm_din2  = d_wdata_q;
                mm_size  = d_size_q;
                mm_sign  = d_sign_q;
                if (mm_valid2) begin
                    d_valid = 1'b1;
                    d_rdata = d_we_q ? 32'h0000_0000 : mm_dout2;
                    more_d  = 1'b0;
                    state_d = RECOVER;
                end else if (timeout_s) begin
                    d_valid = 1'b1;
                    d_rdata = DEAD_BEEF;
                    more_d  = 1'b0;
                    state_d = RECOVER;
                end else begin
                    state_d = D_ACC;
                end
            end
            RECOVER: begin
                mm_rst_s = 1'b1;
                if (more_q) begin
                    state_d = I_ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and latched data-request registers.
    always_ff @(posedge MEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            d_we_q    <= 1'b0;
            d_addr_q  <= 32'h0000_0000;
            d_wdata_q <= 32'h0000_0000;
            d_size_q  <= 2'd0;
            d_sign_q  <= 1'b0;
            more_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_we_q    <= d_we_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            d_size_q  <= d_size_d;
            d_sign_q  <= d_sign_d;
            more_q    <= more_d;
        end
    end

    // Restart is also held during reset so MainMemory's counter starts clean.
    assign mm_rst = mm_rst_s | ~RST_N;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural MainMemory
// (programmable delay, restart-cleared delay counter, 256-word data array).
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int WPL = 8;
    localparam int IAW = 14;
    localparam int TO  = 16;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] exp_rdata;
    } dvec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_req = 1'b0;
    logic [IAW-1:0]  i_line_addr = '0;
    logic            i_word_valid, i_done, d_valid;
    logic [31:0]     i_word_data, d_rdata;
    logic            d_req = 1'b0, d_we = 1'b0, d_sign = 1'b0;
    logic [31:0]     d_addr = 32'h0, d_wdata = 32'h0;
    logic [1:0]      d_size = 2'd0;
    logic            mm_rden1, mm_valid1, mm_rden2, mm_we2, mm_valid2, mm_sign, mm_rst, busy;
    logic [IAW-1:0]  mm_addr1;
    logic [31:0]     mm_dout1, mm_addr2, mm_din2, mm_dout2;
    logic [1:0]      mm_size;
`ifdef MEM_ARB_TIMEOUT_EN
    logic            err_timeout;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .WORDS_PER_LINE (WPL),
        .IADDR_W        (IAW)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC  (TO)
`endif
    ) dut (
        .MEM_CLK(clk), .RST_N(rst_n),
        .i_req(i_req), .i_line_addr(i_line_addr),
        .i_word_valid(i_word_valid), .i_word_data(i_word_data), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_sign(d_sign), .d_valid(d_valid), .d_rdata(d_rdata),
        .mm_rden1(mm_rden1), .mm_addr1(mm_addr1), .mm_dout1(mm_dout1), .mm_valid1(mm_valid1),
        .mm_rden2(mm_rden2), .mm_we2(mm_we2), .mm_addr2(mm_addr2), .mm_din2(mm_din2),
        .mm_size(mm_size), .mm_sign(mm_sign), .mm_dout2(mm_dout2), .mm_valid2(mm_valid2),
        .mm_rst(mm_rst), .busy(busy)
`ifdef MEM_ARB_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    // ---------------- MainMemory model ----------------
    int          mem_delay = 8;
    int          mcnt = 0;
    logic        kill_v2 = 1'b0, force_v1 = 1'b0, force_v2 = 1'b0;
    logic [31:0] dmem [0:255];

    initial for (int i = 0; i < 256; i++) dmem[i] = 32'h0;

    always @(posedge clk) begin
        if (mm_rst) mcnt <= 0;
        else if (mm_rden1 || mm_rden2 || mm_we2) mcnt <= mcnt + 1;
        if (mm_we2 && mm_valid2) dmem[mm_addr2[9:2]] <= mm_din2;
    end

    assign mm_valid1 = force_v1 | (mm_rden1 && (mcnt == mem_delay - 1));
    assign mm_valid2 = force_v2 | (!kill_v2 && (mm_rden2 || mm_we2) && (mcnt == mem_delay - 1));
    assign mm_dout1  = 32'h1000_0000 | {18'h0, mm_addr1};
    assign mm_dout2  = dmem[mm_addr2[9:2]];

    // ---------------- checking ----------------
    int errors = 0, checks = 0;
    int cyc = 0;
    int i_words_seen = 0;
    int i_first_cyc = -1, i_done_cyc = -1, d_valid_cyc = -1;
    logic prev_valid = 1'b0;
    logic [31:0] exp_i[$];
    dvec_t       exp_d[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard / protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [31:0] ei;
            dvec_t       ed;
            chk("no_port_overlap", {63'h0, mm_rden1 & (mm_rden2 | mm_we2)}, 64'h0);
            chk("mm_rst_after_valid", {63'h0, mm_rst}, {63'h0, prev_valid});
            if (prev_valid) chk("enable_falls", {63'h0, mm_rden1 | mm_rden2 | mm_we2}, 64'h0);
            prev_valid = i_word_valid | d_valid;
            if (i_word_valid) begin
                i_words_seen++;
                if (i_first_cyc < 0) i_first_cyc = cyc;
                if (exp_i.size() == 0) chk("i_word_unexpected", 64'h1, 64'h0);
                else begin
                    ei = exp_i.pop_front();
                    chk("i_word_data", {32'h0, i_word_data}, {32'h0, ei});
                end
            end
            if (i_done) begin
                i_done_cyc = cyc;
                chk("i_done_with_last", {63'h0, i_word_valid}, 64'h1);
                chk("i_done_word_count", 64'(i_words_seen), 64'(WPL));
                i_words_seen = 0;
            end
            if (d_valid) begin
                d_valid_cyc = cyc;
                if (exp_d.size() == 0) chk("d_valid_unexpected", 64'h1, 64'h0);
                else begin
                    ed = exp_d.pop_front();
                    chk("d_rdata", {32'h0, d_rdata}, {32'h0, ed.exp_rdata});
                    chk("mm_addr2", {32'h0, mm_addr2}, {32'h0, ed.addr});
                    chk("mm_size_sign", {61'h0, mm_size, mm_sign}, {61'h0, ed.size, ed.sign});
                end
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    dvec_t inj_vec;

    task automatic drive_d(input dvec_t v);
        d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_size = v.size; d_sign = v.sign;
        d_req = 1'b1;
        exp_d.push_back(v);
    endtask

    task automatic push_line(input logic [IAW-1:0] a, input int nwords);
        logic [IAW-1:0] base;
        base = a & 14'h3FF8;
        for (int k = 0; k < nwords; k++) exp_i.push_back(32'h1000_0000 | {18'h0, base | 14'(k)});
    endtask

    // Runs until both requesters are satisfied and the FSM is idle; counts busy cycles.
    task automatic run(input int inject_after, output int busy_cyc);
        int  words;
        logic fin;
        words = 0; fin = 1'b0; busy_cyc = 0;
        for (int t = 0; t < 3000 && !fin; t++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (i_word_valid) begin
                words++;
                if (words == inject_after) drive_d(inj_vec);
            end
            if (i_done) i_req = 1'b0;
            if (d_valid) d_req = 1'b0;
            if (!i_req && !d_req && !busy) fin = 1'b1;
        end
        if (!fin) begin
            chk("run_bounded", 64'h0, 64'h1);
            i_req = 1'b0; d_req = 1'b0;
        end
    endtask

    task automatic line_fill(input logic [IAW-1:0] a, input int dly, input int exp_busy);
        int n;
        mem_delay = dly; i_done_cyc = -1;
        push_line(a, WPL);
        i_line_addr = a; i_req = 1'b1;
        run(-1, n);
        chk("line_latency", 64'(n), 64'(exp_busy));
        chk("line_i_done_seen", {63'h0, i_done_cyc >= 0}, 64'h1);
        chk("line_queue_drained", 64'(exp_i.size()), 64'h0);
    endtask

    task automatic data_acc(input dvec_t v, input int exp_busy);
        int n;
        drive_d(v);
        run(-1, n);
        chk("data_latency", 64'(n), 64'(exp_busy));
        chk("data_queue_drained", 64'(exp_d.size()), 64'h0);
    endtask

    // ---------------- test sequence ----------------
    dvec_t dvec [7];

    initial begin
        int n;
        dvec[0] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, SIZE_WORD, 1'b0, 32'h0000_0000};
        dvec[1] = '{1'b0, 32'h0000_1000, 32'h0000_0000, SIZE_WORD, 1'b0, 32'hCAFE_F00D};
        dvec[2] = '{1'b1, 32'h0000_1004, 32'h1234_5678, SIZE_WORD, 1'b0, 32'h0000_0000};
        dvec[3] = '{1'b0, 32'h0000_1004, 32'h0000_0000, SIZE_HALF, 1'b1, 32'h1234_5678};
        dvec[4] = '{1'b0, 32'h0000_1008, 32'h0000_0000, SIZE_BYTE, 1'b1, 32'h0000_0000};
        dvec[5] = '{1'b1, 32'h0000_1000, 32'hA5A5_5A5A, SIZE_WORD, 1'b0, 32'h0000_0000};
        dvec[6] = '{1'b0, 32'h0000_1000, 32'h0000_0000, SIZE_WORD, 1'b0, 32'hA5A5_5A5A};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("reset_outputs_zero", {63'h0, |{i_word_valid, i_word_data, i_done, d_valid, d_rdata,
            mm_rden1, mm_addr1, mm_rden2, mm_we2, mm_addr2, mm_din2, mm_size, mm_sign, busy}}, 64'h0);
        chk("reset_mm_rst_high", {63'h0, mm_rst}, 64'h1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {62'h0, busy, mm_rst}, 64'h0);

        // Stray valids while idle are ignored.
        force_v1 = 1'b1; force_v2 = 1'b1;
        #1 chk("idle_valid_ignored", {62'h0, i_word_valid, d_valid}, 64'h0);
        @(negedge clk);
        force_v1 = 1'b0; force_v2 = 1'b0;
        chk("idle_valid_no_grant", {63'h0, busy}, 64'h0);

        // Line fills: 8 words x (delay + 1).
        line_fill(14'h0013, 8, 72);
        line_fill(14'h3FFF, 2, 24);

        // Data table.
        mem_delay = 3;
        for (int i = 0; i < 7; i++) data_acc(dvec[i], 4);

        // Both request on the same edge: data first, then the line.
        mem_delay = 4; i_first_cyc = -1; d_valid_cyc = -1; i_done_cyc = -1;
        push_line(14'h0020, WPL);
        i_line_addr = 14'h0020; i_req = 1'b1;
        drive_d(dvec[6]);
        run(-1, n);
        chk("simul_data_first", {63'h0, (d_valid_cyc >= 0) && (i_first_cyc > d_valid_cyc)}, 64'h1);
        chk("simul_busy_cycles", 64'(n), 64'(5 + 8 * 5));
        chk("simul_i_done", {63'h0, i_done_cyc >= 0}, 64'h1);

        // Data request raised during the 3rd word waits for the whole burst.
        mem_delay = 3; d_valid_cyc = -1; i_done_cyc = -1;
        inj_vec = dvec[3];
        push_line(14'h0100, WPL);
        i_line_addr = 14'h0100; i_req = 1'b1;
        run(2, n);
        chk("inject_after_burst", 64'(d_valid_cyc - i_done_cyc), 64'(2 + 3));
        chk("inject_busy_cycles", 64'(n), 64'(8 * 4 + 4));
        chk("inject_queues_drained", 64'(exp_i.size() + exp_d.size()), 64'h0);

        // Reset in the middle of word 4 of a burst.
        mem_delay = 3; i_done_cyc = -1;
        push_line(14'h0200, 3);
        i_line_addr = 14'h0200; i_req = 1'b1;
        begin
            int words;
            words = 0;
            for (int t = 0; t < 200 && words < 3; t++) begin
                @(negedge clk);
                if (i_word_valid) words++;
            end
            chk("burst_reached_word4", 64'(words), 64'h3);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {63'h0, |{i_word_valid, i_word_data, i_done, d_valid, d_rdata,
            mm_rden1, mm_addr1, mm_rden2, mm_we2, mm_addr2, mm_din2, mm_size, mm_sign, busy}}, 64'h0);
        chk("async_reset_mm_rst", {63'h0, mm_rst}, 64'h1);
        i_req = 1'b0; i_words_seen = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abandoned_no_i_done", {63'h0, i_done_cyc >= 0}, 64'h0);
        chk("abandoned_busy_low", {63'h0, busy}, 64'h0);
        chk("abandoned_queue", 64'(exp_i.size()), 64'h0);
        line_fill(14'h0040, 2, 24);

`ifdef MEM_ARB_TIMEOUT_EN
        // Stalled data access aborts after TO cycles.
        begin
            dvec_t tv;
            tv = '{1'b0, 32'h0000_1000, 32'h0, SIZE_WORD, 1'b0, DEAD_BEEF};
            kill_v2 = 1'b1;
            data_acc(tv, TO + 1);
            kill_v2 = 1'b0;
            repeat (2) @(negedge clk);
            chk("err_timeout_sticky", {63'h0, err_timeout}, 64'h1);
            mem_delay = 3;
            data_acc(dvec[6], 4);
            chk("err_timeout_cleared", {63'h0, err_timeout}, 64'h0);
        end
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
